// File: rtl/coeff_key_encoder.sv
// Keypad-to-coefficient encoder: builds a decimal entry from key strokes, converts it
// to signed 12.4 fixed point and writes it to the next coefficient register.
module coeff_key_encoder #(
   parameter int NUM_COEFF = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [4:0]  key_code,
   output logic        wr_en,
   output logic [3:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        busy,
   output logic        all_loaded,
   output logic        err_ovf,
   output logic        entry_neg
);

   typedef enum logic [2:0] {ST_INT, ST_FRAC, ST_CONV, ST_WRITE, ST_DONE} state_t;

   state_t      state, state_nxt;
   logic [13:0] int_val, int_val_nxt;
   logic [14:0] frac_val, frac_val_nxt;
   logic [2:0]  int_cnt, int_cnt_nxt;
   logic [2:0]  frac_cnt, frac_cnt_nxt;
   logic [1:0]  bit_cnt, bit_cnt_nxt;
   logic [3:0]  frac_bits, frac_bits_nxt;
   logic        neg_nxt, wr_en_nxt, all_loaded_nxt, err_ovf_nxt;
   logic [3:0]  wr_addr_nxt;
   logic [15:0] wr_data_nxt;

   logic        is_digit, clear_all, clr_entry, bit_now, ovf;
   logic [3:0]  digit;
   logic [13:0] weight, frac_add;
   logic [14:0] frac_dbl, frac_sub;
   logic [3:0]  frac_bits_new;
   logic [17:0] mag;

   assign busy = (state == ST_CONV) || (state == ST_WRITE);

   always_comb begin
      state_nxt      = state;
      int_val_nxt    = int_val;
      frac_val_nxt   = frac_val;
      int_cnt_nxt    = int_cnt;
      frac_cnt_nxt   = frac_cnt;
      bit_cnt_nxt    = bit_cnt;
      frac_bits_nxt  = frac_bits;
      neg_nxt        = entry_neg;
      wr_en_nxt      = 1'b0;
      wr_addr_nxt    = wr_addr;
      wr_data_nxt    = wr_data;
      all_loaded_nxt = all_loaded;
      err_ovf_nxt    = err_ovf;
      clr_entry      = 1'b0;

      digit     = key_code[3:0];
      is_digit  = key_valid && (key_code <= 5'd9);
      clear_all = key_valid && (key_code == 5'd14);

      case (frac_cnt)
         3'd0:    weight = 14'd1000;
         3'd1:    weight = 14'd100;
         3'd2:    weight = 14'd10;
         default: weight = 14'd1;
      endcase
      frac_add = {10'b0, digit} * weight;

      // One restoring-style doubling step yields the next binary fraction bit.
      frac_dbl      = {frac_val[13:0], 1'b0};
      bit_now       = frac_dbl >= 15'd10000;
      frac_sub      = bit_now ? (frac_dbl - 15'd10000) : frac_dbl;
      frac_bits_new = {frac_bits[2:0], bit_now};
      // Kept wider than 17 bits so a 4-digit integer part cannot wrap past the range check.
      mag = {int_val, 4'b0000} + {14'b0, frac_bits_new};
      ovf = entry_neg ? (mag > 18'd32768) : (mag > 18'd32767);

      case (state)
         ST_INT, ST_FRAC: begin
            if (is_digit) begin
               if (state == ST_INT && int_cnt < 3'd4) begin
                  int_val_nxt = int_val * 14'd10 + {10'b0, digit};
                  int_cnt_nxt = int_cnt + 3'd1;
                  err_ovf_nxt = 1'b0;
               end else if (state == ST_FRAC && frac_cnt < 3'd4) begin
                  frac_val_nxt = frac_val + {1'b0, frac_add};
                  frac_cnt_nxt = frac_cnt + 3'd1;
                  err_ovf_nxt  = 1'b0;
               end
            end else if (key_valid) begin
               case (key_code)
                  5'd10: state_nxt = ST_FRAC;
                  5'd11: neg_nxt = ~entry_neg;
                  5'd12: begin
                     state_nxt     = ST_CONV;
                     bit_cnt_nxt   = 2'd0;
                     frac_bits_nxt = 4'd0;
                  end
                  5'd13: begin
                     clr_entry = 1'b1;
                     state_nxt = ST_INT;
                  end
                  default: ;
               endcase
            end
         end
         ST_CONV: begin
            frac_val_nxt  = frac_sub;
            frac_bits_nxt = frac_bits_new;
            bit_cnt_nxt   = bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
               if (ovf) begin
                  err_ovf_nxt = 1'b1;
                  clr_entry   = 1'b1;
                  state_nxt   = ST_INT;
               end else begin
                  wr_en_nxt   = 1'b1;
                  wr_data_nxt = entry_neg ? (~mag[15:0] + 16'd1) : mag[15:0];
                  state_nxt   = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            wr_addr_nxt = wr_addr + 4'd1;
            clr_entry   = 1'b1;
            if (wr_addr == 4'(NUM_COEFF - 1)) begin
               all_loaded_nxt = 1'b1;
               state_nxt      = ST_DONE;
            end else begin
               state_nxt = ST_INT;
            end
         end
         default: ;
      endcase

      if (clear_all) begin
         clr_entry      = 1'b1;
         wr_addr_nxt    = 4'd0;
         all_loaded_nxt = 1'b0;
         err_ovf_nxt    = 1'b0;
         wr_en_nxt      = 1'b0;
         state_nxt      = ST_INT;
      end

      if (clr_entry) begin
         int_val_nxt  = 14'd0;
         frac_val_nxt = 15'd0;
         int_cnt_nxt  = 3'd0;
         frac_cnt_nxt = 3'd0;
         neg_nxt      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_INT;
         int_val    <= '0;
         frac_val   <= '0;
         int_cnt    <= '0;
         frac_cnt   <= '0;
         bit_cnt    <= '0;
         frac_bits  <= '0;
         entry_neg  <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         all_loaded <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         state      <= state_nxt;
         int_val    <= int_val_nxt;
         frac_val   <= frac_val_nxt;
         int_cnt    <= int_cnt_nxt;
         frac_cnt   <= frac_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         frac_bits  <= frac_bits_nxt;
         entry_neg  <= neg_nxt;
         wr_en      <= wr_en_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         all_loaded <= all_loaded_nxt;
         err_ovf    <= err_ovf_nxt;
      end
   end

endmodule

// File: tb/tb_coeff_key_encoder.sv
// Scoreboard bench for coeff_key_encoder: directed key sequences push expected writes,
// a negedge monitor pops and compares address, data and latency on every wr_en.
module tb_coeff_key_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [4:0]  key_code = 5'd0;
   logic        wr_en, busy, all_loaded, err_ovf, entry_neg;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int last_cyc = 0;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
      int          cyc;
   } exp_t;
   exp_t q[$];

   coeff_key_encoder #(.NUM_COEFF(12)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .all_loaded(all_loaded), .err_ovf(err_ovf), .entry_neg(entry_neg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wr_en) begin
         if (q.size() == 0) begin
            check("unexpected_wr_en", {28'd0, wr_addr}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
            check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
            check("wr_latency", cyc, e.cyc);
         end
      end
   end

   task automatic press(input int code);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 5'(code);
      last_cyc  = cyc;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic enter_exp(input int addr, input logic [15:0] data);
      exp_t e;
      press(12);
      e.addr = 4'(addr);
      e.data = data;
      e.cyc  = last_cyc + 5;
      q.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         check("write_timeout", q.size(), 0);
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic key_num(input int v);
      if (v >= 10) press(v / 10);
      press(v % 10);
   endtask

   int          vals [12] = '{1, 1, 1, 6, -4, 5, 5, 2, 2, 2, 31, 13};
   logic [15:0] words[12] = '{16'h0010, 16'h0010, 16'h0010, 16'h0060, 16'hFFC0, 16'h0050,
                              16'h0050, 16'h0020, 16'h0020, 16'h0020, 16'h01F0, 16'h00D0};

   initial begin
      repeat (2) @(negedge clk);
      check("rst_outputs", {wr_en, busy, all_loaded, err_ovf, entry_neg}, 5'b0);
      check("rst_addr_data", {wr_addr, wr_data}, 20'h0);
      rst = 1'b0;

      press(3);
      enter_exp(0, 16'h0030);
      wait_drain();
      check("addr_after_first", wr_addr, 4'd1);

      press(4); press(11);
      check("neg_toggled", entry_neg, 1'b1);
      enter_exp(1, 16'hFFC0);
      wait_drain();
      check("neg_cleared", entry_neg, 1'b0);

      press(2); press(10); press(5);
      enter_exp(2, 16'h0028);
      wait_drain();
      press(0); press(10); press(1);
      enter_exp(3, 16'h0001);
      wait_drain();

      press(11); press(2); press(0); press(4); press(8);
      enter_exp(4, 16'h8000);
      wait_drain();

      press(2); press(0); press(4); press(8); press(12);
      repeat (8) @(negedge clk);
      check("ovf_flag", err_ovf, 1'b1);
      check("ovf_addr", wr_addr, 4'd5);

      press(1);
      check("ovf_cleared_by_digit", err_ovf, 1'b0);
      press(2); press(3); press(4); press(5);
      press(10);
      for (int d = 1; d <= 6; d++) press(d);
      press(10);
      enter_exp(5, 16'h4D21);
      wait_drain();

      press(7);
      enter_exp(6, 16'h0070);
      check("busy_in_conv", busy, 1'b1);
      press(9);
      wait_drain();
      check("addr_after_busy", wr_addr, 4'd7);

      press(5); press(12);
      check("busy_before_rst", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_flags", {wr_en, busy, all_loaded, err_ovf, entry_neg}, 5'b0);
      check("async_rst_addr_data", {wr_addr, wr_data}, 20'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         if (vals[i] < 0) press(11);
         key_num(vals[i] < 0 ? -vals[i] : vals[i]);
         enter_exp(i, words[i]);
         wait_drain();
      end
      check("all_loaded", all_loaded, 1'b1);
      press(3); press(12);
      repeat (8) @(negedge clk);
      check("done_holds", all_loaded, 1'b1);
      check("done_addr", wr_addr, 4'd12);

      press(14);
      check("clear_all_flags", {all_loaded, err_ovf}, 2'b00);
      check("clear_all_addr", wr_addr, 4'd0);

      press(11); press(20);
      check("unused_code", entry_neg, 1'b1);
      press(13);
      check("clear_entry_neg", entry_neg, 1'b0);
      press(9); press(13); press(1);
      enter_exp(0, 16'h0010);
      wait_drain();
      check("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
